word_serializer: RTL and testbench
==================================

Name: word_serializer

Overview:
- Reader end of a register-captured word stream: accepts one WIDTH-bit word per valid/ready handshake and emits it as WIDTH/OUT_WIDTH narrow beats on a valid/ready output.
- Sits between accelerator datapath output registers and narrow output buses (e.g. result drain to a host link).
- The word is held in an internal write-enabled register while it drains.

Parameters:
- WIDTH, 32, input word width in bits. Must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 8, output beat width in bits.
- BEATS, WIDTH/OUT_WIDTH (derived localparam), beats per word. Must be at least 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- arst_n_in  input  1  asynchronous reset, active low.
- in_valid  input  1  producer presents in_data.
- in_ready  output  1  serializer can accept a word this cycle.
- in_data  input  WIDTH  word to serialize.
- out_valid  output  1  out_data holds a valid beat.
- out_ready  input  1  consumer accepts the beat this cycle.
- out_data  output  OUT_WIDTH  current beat.
- out_last  output  1  current beat is the final beat of the word.

Behaviour:
- Reset (arst_n_in=0, asynchronous): state=IDLE, beat counter=0, hold register=0, out_valid=0, out_last=0, out_data=0, in_ready=1 once reset is released.
- States:
  - IDLE: out_valid=0, in_ready=1. If in_valid=1, capture in_data into the hold register, set counter=0, go to SEND.
  - SEND: out_valid=1. out_data = hold[cnt*OUT_WIDTH +: OUT_WIDTH], LSB slice first. out_last=(cnt==BEATS-1).
- Beat advance in SEND:
  - out_valid & out_ready with cnt<BEATS-1: cnt+1.
  - Handshake on the last beat: cnt returns to 0. Next state is SEND if a new word is accepted that cycle, otherwise IDLE.
- Back-to-back rule: in_ready = (state==IDLE) | (state==SEND & out_last & out_ready). This allows zero-bubble streaming of consecutive words, with sustained throughput of 1 beat per cycle.
- Latency: a word accepted in cycle N presents beat 0 in cycle N+1.
- Stall: while out_valid=1 and out_ready=0, out_data, out_last and cnt hold stable. The data may not change until the handshake.
- in_ready is a combinational function of state, cnt and out_ready. out_valid, out_data and out_last depend on registered state only.
- BEATS==1: every beat is last. The block behaves as a one-entry pipeline register with in_ready = ~out_valid | out_ready.
- in_data is ignored when in_ready=0. in_valid may be asserted during SEND without effect until the last-beat handshake.
- Reset mid-word: the partial word is discarded and no further beats are emitted. After release, the block is in IDLE.
- Counter width: $clog2(BEATS), minimum 1 bit. No wrap except the explicit return to 0 on the last beat.

Optional Feature:
- Macro: SERIALIZER_MSB_FIRST_EN.
- Defined: beat order is reversed. Beat k = hold[(BEATS-1-k)*OUT_WIDTH +: OUT_WIDTH], so the most significant slice goes first. out_last and all handshake timing are unchanged.
- Undefined: LSB-first order as described above.

Test Plan:
- Reset then idle: arst_n_in pulsed low mid-cycle -> out_valid=0, out_data=0, in_ready=1 immediately. Nothing is emitted with in_valid=0.
- Single word, out_ready=1: in_data=32'hDDCCBBAA accepted in cycle 0 -> beats AA,BB,CC,DD in cycles 1-4, out_last=1 only with DD, then IDLE. With SERIALIZER_MSB_FIRST_EN: DD,CC,BB,AA.
- Back-to-back: words 32'h03020100 and 32'h07060504 with in_valid held, out_ready=1 -> 8 consecutive beats 00..07 with no bubble. in_ready is high in the cycles of beat 0x03 and beat 0x07.
- Backpressure: out_ready=0 for 3 cycles during beat 1 of 32'h44332211 -> out_data stays 0x22, in_ready=0, and the sequence resumes with 0x33 after out_ready=1.
- Reset mid-word: arst_n_in low after beat 0x11 of 32'h44332211 -> out_valid drops asynchronously. After release, a new word 32'hA5A5A5A5 streams from beat 0 (A5) and no stale 0x22 appears.
- BEATS=1 (WIDTH=OUT_WIDTH=8): random valid/ready stimulus, 100 words -> output order equals input order, no loss or duplication, and out_last=1 on every beat.

Source files
------------

// File: rtl/word_serializer_if.sv
// Handshake bundle for word_serializer: wide word in, narrow beats out.
// slave = serializer side, master = producer/consumer side.
interface word_serializer_if #(
  parameter int WIDTH     = 32,
  parameter int OUT_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/word_serializer.sv
// Captures one WIDTH-bit word per handshake and drains it as WIDTH/OUT_WIDTH beats.
// Define SERIALIZER_MSB_FIRST_EN to emit the most significant slice first.
module word_serializer #(
  parameter int WIDTH     = 32,
  parameter int OUT_WIDTH = 8
) (
  input  logic              clk,
  input  logic              arst_n_in,
  word_serializer_if.slave  bus
);
  localparam int BEATS = WIDTH / OUT_WIDTH;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef logic [BEATS-1:0][OUT_WIDTH-1:0] word_t;
  typedef enum logic {IDLE, SEND} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  word_t                hold;
  logic                 vld_q;
  logic                 last_q;
  logic [OUT_WIDTH-1:0] data_q;

  logic [CW-1:0] nxt;
  logic          accept;
  logic          fire;

  function automatic logic [OUT_WIDTH-1:0] beat_of(input word_t w, input logic [CW-1:0] k);
`ifdef SERIALIZER_MSB_FIRST_EN
    return w[CW'(BEATS-1) - k];
`else
    return w[k];
`endif
  endfunction

  // A new word may enter while the last beat of the current one is taken.
  assign bus.in_ready = (state == IDLE) | ((state == SEND) & last_q & bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  assign fire         = vld_q & bus.out_ready;
  assign nxt          = cnt + CW'(1);

  assign bus.out_valid = vld_q;
  assign bus.out_last  = last_q;
  assign bus.out_data  = data_q;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state  <= IDLE;
      cnt    <= '0;
      hold   <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      data_q <= '0;
    end else if (accept) begin
      state  <= SEND;
      cnt    <= '0;
      hold   <= bus.in_data;
      vld_q  <= 1'b1;
      last_q <= (BEATS == 1);
      data_q <= beat_of(bus.in_data, '0);
    end else if (fire) begin
      if (last_q) begin
        state  <= IDLE;
        cnt    <= '0;
        vld_q  <= 1'b0;
        last_q <= 1'b0;
        data_q <= '0;
      end else begin
        cnt    <= nxt;
        last_q <= (nxt == CW'(BEATS-1));
        data_q <= beat_of(hold, nxt);
      end
    end
  end
endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: 32->8 instance plus a 8->8 (single beat) instance.
`timescale 1ns/1ps
module tb_word_serializer;
  logic clk = 1'b0;
  logic arst_n_in = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  word_serializer_if #(.WIDTH(32), .OUT_WIDTH(8)) b4 ();
  word_serializer_if #(.WIDTH(8),  .OUT_WIDTH(8)) b1 ();

  word_serializer #(.WIDTH(32), .OUT_WIDTH(8)) u4 (.clk(clk), .arst_n_in(arst_n_in), .bus(b4));
  word_serializer #(.WIDTH(8),  .OUT_WIDTH(8)) u1 (.clk(clk), .arst_n_in(arst_n_in), .bus(b1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte expected on beat k of word w, in the configured beat order.
  function automatic logic [7:0] exp_beat(input logic [31:0] w, input int k);
    logic [31:0] t;
    t = w;
`ifdef SERIALIZER_MSB_FIRST_EN
    return t[(3-k)*8 +: 8];
`else
    return t[k*8 +: 8];
`endif
  endfunction

  // Advance one cycle; inputs are then driven and outputs sampled mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [31:0] d, input logic r);
    b4.in_valid  = v;
    b4.in_data   = d;
    b4.out_ready = r;
    #1;
  endtask

  task automatic chk_beat(input string tag, input logic [7:0] d, input logic last, input logic rdy);
    chk({tag, ".valid"}, {31'd0, b4.out_valid}, 32'd1);
    chk({tag, ".data"},  {24'd0, b4.out_data},  {24'd0, d});
    chk({tag, ".last"},  {31'd0, b4.out_last},  {31'd0, last});
    chk({tag, ".in_ready"}, {31'd0, b4.in_ready}, {31'd0, rdy});
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, {31'd0, b4.out_valid}, 32'd0);
    chk({tag, ".in_ready"}, {31'd0, b4.in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  q[$];
    logic [7:0]  nd;
    int          got_n;
    int          cyc;

    b4.in_valid = 0; b4.in_data = '0; b4.out_ready = 0;
    b1.in_valid = 0; b1.in_data = '0; b1.out_ready = 0;

    // reset asserted mid-cycle
    #3 arst_n_in = 1'b0;
    #1;
    chk("rst.valid", {31'd0, b4.out_valid}, 32'd0);
    chk("rst.data",  {24'd0, b4.out_data},  32'd0);
    chk("rst.last",  {31'd0, b4.out_last},  32'd0);
    chk("rst.in_ready", {31'd0, b4.in_ready}, 32'd1);
    chk("rst1.valid", {31'd0, b1.out_valid}, 32'd0);
    step(); step();
    arst_n_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); put(0, 32'h0, 1);
      chk_idle("idle");
    end

    // single word
    step(); put(1, 32'hDDCCBBAA, 1);
    chk("single.in_ready", {31'd0, b4.in_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      step(); put(0, 32'h0, 1);
      chk_beat($sformatf("single.b%0d", k), exp_beat(32'hDDCCBBAA, k), k == 3, k == 3);
    end
    step(); put(0, 32'h0, 1);
    chk_idle("single.end");

    // back-to-back, second word offered from beat 0 of the first
    step(); put(1, 32'h03020100, 1);
    for (int k = 0; k < 8; k++) begin
      step();
      put(k < 4, 32'h07060504, 1);
      w = (k < 4) ? 32'h03020100 : 32'h07060504;
      chk_beat($sformatf("b2b.b%0d", k), exp_beat(w, k % 4), (k % 4) == 3, (k % 4) == 3);
    end
    step(); put(0, 32'h0, 1);
    chk_idle("b2b.end");

    // backpressure on beat 1, with a competing word offered during the stall
    step(); put(1, 32'h44332211, 1);
    step(); put(0, 32'h0, 1);
    chk_beat("bp.b0", exp_beat(32'h44332211, 0), 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(); put(1, 32'hEEEEEEEE, 0);
      chk_beat($sformatf("bp.stall%0d", i), exp_beat(32'h44332211, 1), 0, 0);
    end
    step(); put(0, 32'h0, 1);
    chk_beat("bp.b1", exp_beat(32'h44332211, 1), 0, 0);
    step(); put(0, 32'h0, 1);
    chk_beat("bp.b2", exp_beat(32'h44332211, 2), 0, 0);
    step(); put(0, 32'h0, 1);
    chk_beat("bp.b3", exp_beat(32'h44332211, 3), 1, 1);
    step(); put(0, 32'h0, 1);
    chk_idle("bp.end");

    // reset in the middle of a word
    step(); put(1, 32'h44332211, 1);
    step(); put(0, 32'h0, 1);
    chk_beat("mid.b0", exp_beat(32'h44332211, 0), 0, 0);
    step(); put(0, 32'h0, 0);
    chk("mid.pre.valid", {31'd0, b4.out_valid}, 32'd1);
    #1 arst_n_in = 1'b0;
    #1;
    chk("mid.rst.valid", {31'd0, b4.out_valid}, 32'd0);
    chk("mid.rst.data",  {24'd0, b4.out_data},  32'd0);
    step();
    arst_n_in = 1'b1;
    step(); put(0, 32'h0, 1);
    chk_idle("mid.post");
    step(); put(1, 32'hA5A5A5A5, 1);
    for (int k = 0; k < 4; k++) begin
      step(); put(0, 32'h0, 1);
      chk_beat($sformatf("mid.new.b%0d", k), 8'hA5, k == 3, k == 3);
    end
    step(); put(0, 32'h0, 1);
    chk_idle("mid.end");

    // single-beat instance under random valid/ready
    nd = 8'h00; got_n = 0; cyc = 0;
    while (got_n < 100 && cyc < 3000) begin
      step();
      if (!(b1.in_valid && !b1.in_ready)) b1.in_valid = ($urandom_range(0, 3) != 0);
      b1.in_data   = nd;
      b1.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      chk("one.in_ready", {31'd0, b1.in_ready}, {31'd0, (~b1.out_valid) | b1.out_ready});
      if (b1.out_valid && b1.out_ready) begin
        chk("one.last", {31'd0, b1.out_last}, 32'd1);
        if (q.size() == 0) chk("one.spurious", {24'd0, b1.out_data}, 32'hFFFF_FFFF);
        else               chk("one.data", {24'd0, b1.out_data}, {24'd0, q.pop_front()});
        got_n++;
      end
      if (b1.in_valid && b1.in_ready) begin
        q.push_back(nd);
        nd = nd + 8'd1;
      end
      cyc++;
    end
    chk("one.count", got_n, 32'd100);
    b1.in_valid = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
